// File: rtl/bsg_vanilla_idiv_seq_if.sv
// ----------------------------------------------------------------------------
// bsg_vanilla_idiv_seq_if
//
// Request/response bundle between the vanilla core EXE stage and the
// iterative divide unit.
//
// Signals (direction as seen by the divide unit):
//   v_i       in   request valid
//   ready_o   out  unit can accept a request
//   op_i      in   idiv_op_e (eDIV=0, eDIVU=1, eREM=2, eREMU=3)
//   rs1_i     in   dividend
//   rs2_i     in   divisor
//   rd_i      in   destination register
//   v_o       out  result valid
//   result_o  out  quotient (DIV/DIVU) or remainder (REM/REMU)
//   rd_o      out  destination register of the result
//   yumi_i    in   consumer takes the result (only while v_o=1)
//
// Modports: master = core side, slave = divide unit.
// ----------------------------------------------------------------------------
interface bsg_vanilla_idiv_seq_if #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
);
    logic                        v_i;
    logic                        ready_o;
    logic [1:0]                  op_i;
    logic [data_width_p-1:0]     rs1_i;
    logic [data_width_p-1:0]     rs2_i;
    logic [reg_addr_width_p-1:0] rd_i;
    logic                        v_o;
    logic [data_width_p-1:0]     result_o;
    logic [reg_addr_width_p-1:0] rd_o;
    logic                        yumi_i;

    modport master (
        output v_i, op_i, rs1_i, rs2_i, rd_i, yumi_i,
        input  ready_o, v_o, result_o, rd_o
    );

    modport slave (
        input  v_i, op_i, rs1_i, rs2_i, rd_i, yumi_i,
        output ready_o, v_o, result_o, rd_o
    );
endinterface

// File: rtl/bsg_vanilla_idiv_seq.sv
// ----------------------------------------------------------------------------
// bsg_vanilla_idiv_seq
//
// Iterative integer divide unit (DIV, DIVU, REM, REMU). A restoring
// shift-subtract datapath retires one quotient bit per cycle on unsigned
// magnitudes; signs are restored combinationally once the result is ready.
//
// Ports:
//   clk_i    core clock
//   reset_i  synchronous, active-high reset
//   bus      bsg_vanilla_idiv_seq_if.slave (request, result, valid/yumi)
//
// FSM: IDLE -> CALC (data_width_p cycles) -> DONE -> IDLE on yumi.
//
// Optional feature, macro BSG_VANILLA_IDIV_EARLY_OUT_EN:
//   when defined, a zero divisor or |dividend| < |divisor| skips CALC and
//   goes IDLE -> DONE directly. Results are identical either way.
// ----------------------------------------------------------------------------
module bsg_vanilla_idiv_seq #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bsg_vanilla_idiv_seq_if.slave  bus
);

    localparam int cnt_width_lp = $clog2(data_width_p);
    localparam logic [cnt_width_lp-1:0] last_iter_lp = cnt_width_lp'(data_width_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        eDIV  = 2'd0,
        eDIVU = 2'd1,
        eREM  = 2'd2,
        eREMU = 2'd3
    } idiv_op_e;

    state_e                      r_state;
    idiv_op_e                    r_op;
    logic [reg_addr_width_p-1:0] r_rd;
    logic                        r_neg_quot;   // operand signs differed (signed ops)
    logic                        r_neg_rem;    // dividend was negative (signed ops)
    logic                        r_div_zero;
    logic [data_width_p-1:0]     r_dividend;   // raw dividend, returned on divide by zero
    logic [data_width_p-1:0]     r_divisor;    // divisor magnitude
    logic [data_width_p-1:0]     r_quot;       // dividend shifts out, quotient shifts in
    logic [data_width_p-1:0]     r_rem;
    logic [cnt_width_lp-1:0]     r_cnt;

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    logic                    w_signed_op;
    logic                    w_rs1_neg;
    logic                    w_rs2_neg;
    logic                    w_rs2_zero;
    logic [data_width_p-1:0] w_rs1_mag;
    logic [data_width_p-1:0] w_rs2_mag;

    assign w_signed_op = (bus.op_i == eDIV) || (bus.op_i == eREM);
    assign w_rs1_neg   = w_signed_op & bus.rs1_i[data_width_p-1];
    assign w_rs2_neg   = w_signed_op & bus.rs2_i[data_width_p-1];
    assign w_rs2_zero  = (bus.rs2_i == '0);
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign w_rs1_mag   = w_rs1_neg ? -bus.rs1_i : bus.rs1_i;
    assign w_rs2_mag   = w_rs2_neg ? -bus.rs2_i : bus.rs2_i;

`ifdef BSG_VANILLA_IDIV_EARLY_OUT_EN
    logic w_early_out;
    assign w_early_out = w_rs2_zero || (w_rs1_mag < w_rs2_mag);
`endif

    // ------------------------------------------------------------------
    // One restoring iteration. The shifted partial remainder can reach
    // 2*divisor-1, so it needs one extra bit before the trial subtract.
    // ------------------------------------------------------------------
    logic [data_width_p:0] w_rem_shift;
    logic [data_width_p:0] w_trial;
    logic                  w_fits;

    assign w_rem_shift = {r_rem, r_quot[data_width_p-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = (w_rem_shift >= {1'b0, r_divisor});

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: all datapath registers are cleared too; none of them is
            // a memory array, so resetting them is cheap and keeps outputs
            // deterministic out of reset.
            r_state    <= IDLE;
            r_op       <= eDIV;
            r_rd       <= '0;
            r_neg_quot <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.v_i) begin
                        r_op       <= idiv_op_e'(bus.op_i);
                        r_rd       <= bus.rd_i;
                        r_neg_quot <= w_rs1_neg ^ w_rs2_neg;
                        r_neg_rem  <= w_rs1_neg;
                        r_div_zero <= w_rs2_zero;
                        r_dividend <= bus.rs1_i;
                        r_divisor  <= w_rs2_mag;
                        r_cnt      <= '0;
`ifdef BSG_VANILLA_IDIV_EARLY_OUT_EN
                        if (w_early_out) begin
                            // Quotient is 0 and the remainder is the whole
                            // dividend; divide by zero is overridden at output.
                            r_quot  <= '0;
                            r_rem   <= w_rs1_mag;
                            r_state <= DONE;
                        end else begin
                            r_quot  <= w_rs1_mag;
                            r_rem   <= '0;
                            r_state <= CALC;
                        end
`else
                        r_quot  <= w_rs1_mag;
                        r_rem   <= '0;
                        r_state <= CALC;
`endif
                    end
                end

                CALC: begin
                    r_rem  <= w_fits ? w_trial[data_width_p-1:0]
                                     : w_rem_shift[data_width_p-1:0];
                    r_quot <= {r_quot[data_width_p-2:0], w_fits};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == last_iter_lp) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    if (bus.yumi_i) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result selection and sign fix-up (from registers only)
    // ------------------------------------------------------------------
    logic [data_width_p-1:0] w_result;

    // NOTE: the default assignment first keeps this block free of latches
    // whatever path the case takes.
    always_comb begin
        w_result = '0;
        case (r_op)
            eDIV:    w_result = r_div_zero ? '1 : (r_neg_quot ? -r_quot : r_quot);
            eDIVU:   w_result = r_div_zero ? '1 : r_quot;
            eREM:    w_result = r_div_zero ? r_dividend : (r_neg_rem ? -r_rem : r_rem);
            eREMU:   w_result = r_div_zero ? r_dividend : r_rem;
            default: w_result = '0;
        endcase
    end

    // ready_o is masked by reset so the core never sees a stale IDLE while
    // reset is being applied; otherwise both flags are pure state decodes.
    assign bus.ready_o  = (r_state == IDLE) & ~reset_i;
    assign bus.v_o      = (r_state == DONE);
    assign bus.result_o = w_result;
    assign bus.rd_o     = r_rd;

    // The consumer may only take a result that is being offered.
    a_yumi_only_in_done : assert property (
        @(posedge clk_i) disable iff (reset_i) bus.yumi_i |-> (r_state == DONE)
    );

endmodule
